// File: rtl/gpio_tx_feeder.sv
// Command-driven write sequencer for the GPIO tx FIFO: expands each accepted
// command into repeated, optionally inverted and spaced, FIFO writes that stall on wfull.
module gpio_tx_feeder #(
    parameter int DSIZE = 8,
    parameter int RW    = 4,
    parameter int GW    = 4,
    parameter int CNTW  = 16
) (
    input  logic             wclk,
    input  logic             wrst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [DSIZE-1:0] cmd_data,
    input  logic [RW-1:0]    cmd_repeat,
    input  logic [GW-1:0]    cmd_gap,
    input  logic             cmd_invert,
    input  logic             cmd_abort,
    input  logic             wfull,
    output logic             winc,
    output logic [DSIZE-1:0] wdata,
    output logic             busy,
    output logic [CNTW-1:0]  words_written
);

    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

    localparam logic [RW-1:0]   REM_ONE = 1;
    localparam logic [GW-1:0]   GAP_ONE = 1;
    localparam logic [CNTW-1:0] CNT_ONE = 1;
    localparam logic [CNTW-1:0] CNT_MAX = '1;

    state_t           state;
    logic [DSIZE-1:0] cur_data;
    logic [RW-1:0]    remain;
    logic [GW-1:0]    gap_ld;
    logic [GW-1:0]    gap_cnt;
    logic             inv;

    // Ready is masked by reset so nothing is accepted while the block is held.
    assign cmd_ready = (state == IDLE) & ~wrst;
    assign winc      = (state == ISSUE) & ~wfull & ~cmd_abort;
    assign wdata     = cur_data;
    assign busy      = (state != IDLE);

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            state         <= IDLE;
            cur_data      <= '0;
            remain        <= '0;
            gap_ld        <= '0;
            gap_cnt       <= '0;
            inv           <= 1'b0;
            words_written <= '0;
        end else begin
            if (winc && words_written != CNT_MAX)
                words_written <= words_written + CNT_ONE;

            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cur_data <= cmd_data;
                        remain   <= cmd_repeat;
                        gap_ld   <= cmd_gap;
                        inv      <= cmd_invert;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cmd_abort) begin
                        state <= IDLE;
                    end else if (!wfull) begin
                        if (remain == '0) begin
                            state <= IDLE;
                        end else begin
                            remain   <= remain - REM_ONE;
                            cur_data <= inv ? ~cur_data : cur_data;
                            if (gap_ld != '0) begin
                                gap_cnt <= gap_ld;
                                state   <= GAP;
                            end
                        end
                    end
                end
                GAP: begin
                    // gap_cnt is never zero here, so the decrement cannot wrap.
                    if (cmd_abort) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_ONE;
                        if (gap_cnt == GAP_ONE)
                            state <= ISSUE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_tx_feeder.sv
// Scoreboard bench for gpio_tx_feeder: expected write data is queued when a
// command is driven and popped by a negedge monitor as winc pulses appear.
module tb_gpio_tx_feeder;
    localparam int DSIZE = 8;
    localparam int RW    = 4;
    localparam int GW    = 4;
    localparam int CNTW  = 5;

    logic             wclk = 1'b0;
    logic             wrst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [DSIZE-1:0] cmd_data;
    logic [RW-1:0]    cmd_repeat;
    logic [GW-1:0]    cmd_gap;
    logic             cmd_invert;
    logic             cmd_abort;
    logic             wfull;
    logic             winc;
    logic [DSIZE-1:0] wdata;
    logic             busy;
    logic [CNTW-1:0]  words_written;

    gpio_tx_feeder #(.DSIZE(DSIZE), .RW(RW), .GW(GW), .CNTW(CNTW)) dut (
        .wclk(wclk), .wrst(wrst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_data(cmd_data), .cmd_repeat(cmd_repeat), .cmd_gap(cmd_gap),
        .cmd_invert(cmd_invert), .cmd_abort(cmd_abort),
        .wfull(wfull), .winc(winc), .wdata(wdata),
        .busy(busy), .words_written(words_written)
    );

    always #5 wclk = ~wclk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int nwr   = 0;
    logic [DSIZE-1:0] exp_q[$];
    int wr_cyc[$];

    always @(posedge wclk) cyc++;

    // Write monitor: every strobe must match the scoreboard head and never hit a full FIFO.
    always @(negedge wclk) begin
        if (winc) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write got=%02h expected=none", wdata);
            end else begin
                logic [DSIZE-1:0] e;
                e = exp_q.pop_front();
                if (wdata !== e || wfull !== 1'b0) begin
                    bad++;
                    $display("FAIL write_data got=%02h wfull=%b expected=%02h wfull=0", wdata, wfull, e);
                end
            end
            nwr++;
            wr_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic clear_sb();
        exp_q.delete();
        wr_cyc.delete();
        nwr = 0;
    endtask

    task automatic do_reset();
        tick();
        wrst = 1'b1;
        clear_sb();
        #2;
        wrst = 1'b0;
    endtask

    // Drives one command from an idle DUT; returns at acceptance edge + 1.
    task automatic send_cmd(input logic [7:0] d, input int rep, input int gap, input logic iv);
        logic [7:0] m;
        m = d;
        for (int i = 0; i <= rep; i++) begin
            exp_q.push_back(m);
            if (iv) m = ~m;
        end
        tick();
        cmd_valid  = 1'b1;
        cmd_data   = d;
        cmd_repeat = RW'(rep);
        cmd_gap    = GW'(gap);
        cmd_invert = iv;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL wait_idle_timeout busy=%b expected=0", busy);
        end
    endtask

    task automatic test_reset();
        wrst = 1'b1; cmd_valid = 1'b1; cmd_data = 8'h5A; cmd_repeat = '0;
        cmd_gap = '0; cmd_invert = 1'b0; cmd_abort = 1'b0; wfull = 1'b0;
        #12;
        total++;
        if (winc !== 1'b0 || wdata !== 8'h00 || cmd_ready !== 1'b0 || busy !== 1'b0 || words_written !== '0) begin
            bad++;
            $display("FAIL reset_state winc=%b wdata=%02h ready=%b busy=%b ww=%0d expected 0/00/0/0/0",
                     winc, wdata, cmd_ready, busy, words_written);
        end
        wrst = 1'b0;
        cmd_valid = 1'b0;
        #1;
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready got=%b expected=1", cmd_ready);
        end
    endtask

    task automatic test_single();
        do_reset();
        send_cmd(8'hA5, 0, 0, 1'b0);
        total++;
        if (busy !== 1'b1 || winc !== 1'b1 || wdata !== 8'hA5) begin
            bad++;
            $display("FAIL single_first busy=%b winc=%b wdata=%02h expected 1/1/a5", busy, winc, wdata);
        end
        tick();
        total++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || words_written !== 5'd1 || nwr !== 1) begin
            bad++;
            $display("FAIL single_done busy=%b ready=%b ww=%0d writes=%0d expected 0/1/1/1",
                     busy, cmd_ready, words_written, nwr);
        end
    endtask

    task automatic test_gap_pattern();
        do_reset();
        send_cmd(8'h0F, 3, 2, 1'b1);
        wait_idle(50);
        total++;
        if (nwr !== 4 || words_written !== 5'd4 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL gap_count writes=%0d ww=%0d left=%0d expected 4/4/0", nwr, words_written, exp_q.size());
        end
        for (int i = 0; i + 1 < wr_cyc.size(); i++) begin
            total++;
            if (wr_cyc[i+1] - wr_cyc[i] != 3) begin
                bad++;
                $display("FAIL gap_spacing idx=%0d got=%0d expected=3", i, wr_cyc[i+1] - wr_cyc[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int acc;
        do_reset();
        send_cmd(8'h3C, 15, 0, 1'b0);
        acc = cyc;
        for (int i = 0; i < 4; i++) tick();
        wfull = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        wfull = 1'b0;
        wait_idle(60);
        total++;
        if (nwr !== 16 || words_written !== 5'd16 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL bp_count writes=%0d ww=%0d left=%0d expected 16/16/0", nwr, words_written, exp_q.size());
        end
        total++;
        if (wr_cyc.size() != 16 || wr_cyc[15] - acc + 1 != 21) begin
            bad++;
            $display("FAIL bp_duration got=%0d expected=21", wr_cyc.size() == 16 ? wr_cyc[15] - acc + 1 : -1);
        end
    endtask

    task automatic test_abort();
        do_reset();
        send_cmd(8'h77, 7, 0, 1'b0);
        tick();
        tick();
        cmd_abort = 1'b1;
        #1;
        total++;
        if (winc !== 1'b0) begin
            bad++;
            $display("FAIL abort_suppress winc=%b expected=0", winc);
        end
        tick();
        cmd_abort = 1'b0;
        exp_q.delete();
        total++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || nwr !== 2 || words_written !== 5'd2) begin
            bad++;
            $display("FAIL abort_idle busy=%b ready=%b writes=%0d ww=%0d expected 0/1/2/2",
                     busy, cmd_ready, nwr, words_written);
        end
    endtask

    task automatic test_reset_midop();
        do_reset();
        send_cmd(8'hC3, 15, 1, 1'b1);
        for (int i = 0; i < 6; i++) tick();
        total++;
        if (winc !== 1'b1 || nwr !== 3) begin
            bad++;
            $display("FAIL midop_pre winc=%b writes=%0d expected 1/3", winc, nwr);
        end
        #1;
        wrst = 1'b1;
        exp_q.delete();
        #1;
        total++;
        if (winc !== 1'b0 || words_written !== '0 || busy !== 1'b0 || wdata !== 8'h00) begin
            bad++;
            $display("FAIL midop_reset winc=%b ww=%0d busy=%b wdata=%02h expected 0/0/0/00",
                     winc, words_written, busy, wdata);
        end
        wrst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        total++;
        if (nwr !== 3 || words_written !== '0) begin
            bad++;
            $display("FAIL midop_quiet writes=%0d ww=%0d expected 3/0", nwr, words_written);
        end
        send_cmd(8'h81, 1, 0, 1'b1);
        wait_idle(20);
        total++;
        if (nwr !== 5 || words_written !== 5'd2 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL midop_resume writes=%0d ww=%0d left=%0d expected 5/2/0", nwr, words_written, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic r;
        int n;
        do_reset();
        send_cmd(8'h11, 1, 0, 1'b0);
        exp_q.push_back(8'h22);
        cmd_valid = 1'b1; cmd_data = 8'h22; cmd_repeat = '0; cmd_gap = '0; cmd_invert = 1'b0;
        r = 1'b0;
        n = 0;
        while (!r && n < 20) begin
            @(negedge wclk);
            r = cmd_ready;
            tick();
            n++;
        end
        cmd_valid = 1'b0;
        wait_idle(20);
        total++;
        if (nwr !== 3 || wr_cyc.size() != 3 || wr_cyc[1] - wr_cyc[0] != 1 || wr_cyc[2] - wr_cyc[1] != 2) begin
            bad++;
            $display("FAIL b2b_timing writes=%0d expected 3 with gaps 1,2", nwr);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            send_cmd(8'hE0 + 8'(k), 15, 0, 1'b0);
            wait_idle(40);
        end
        total++;
        if (words_written !== 5'd31 || nwr !== 48) begin
            bad++;
            $display("FAIL saturate ww=%0d writes=%0d expected 31/48", words_written, nwr);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_gap_pattern();
        test_backpressure();
        test_abort();
        test_reset_midop();
        test_back_to_back();
        test_saturate();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout reached expected=finish");
        $fatal(1);
    end
endmodule

// File: doc/gpio_tx_feeder.md
# gpio_tx_feeder

Command-driven write-side sequencer that sits directly upstream of the GPIO transmit FIFO write port (wclk domain). It accepts one command at a time (data byte, repeat count, inter-write gap, invert flag) over a valid/ready handshake. It expands each command into a stream of FIFO writes on winc/wdata, and stalls on wfull so no write is ever lost or issued into a full FIFO.

## Interface
- DSIZE, 8, FIFO data width (matches tx FIFO wdata)
- RW, 4, width of cmd_repeat
- GW, 4, width of cmd_gap
- CNTW, 16, width of words_written
- wclk  in  1  write-domain clock, all logic on rising edge
- wrst  in  1  reset, asynchronous, active-high; one clock, no other reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_data  in  DSIZE  first data word of the command
- cmd_repeat  in  RW  number of writes minus one (0 → 1 write, 15 → 16 writes)
- cmd_gap  in  GW  idle cycles inserted between successive writes
- cmd_invert  in  1  1: bitwise-invert data after every write
- cmd_abort  in  1  synchronous abort of the command in progress
- wfull  in  1  tx FIFO full flag (wclk domain)
- winc  out  1  FIFO write strobe, one write per cycle high
- wdata  out  DSIZE  FIFO write data, valid whenever winc=1
- busy  out  1  command in progress
- words_written  out  CNTW  total accepted writes since reset, saturating

## Operation
- States: IDLE, ISSUE, GAP. The state register resets asynchronously to IDLE.
- IDLE:
  - cmd_ready = (state==IDLE) & !wrst.
  - A command is accepted on an edge with cmd_valid & cmd_ready.
  - On acceptance, cur_data←cmd_data, remain←cmd_repeat, gap_ld←cmd_gap and inv←cmd_invert are latched, and the state moves to ISSUE.
  - cmd_* inputs are ignored outside IDLE.
- ISSUE:
  - winc = (state==ISSUE) & !wfull & !cmd_abort. This is combinational from registered state and inputs.
  - wdata is the registered cur_data.
  - A write completes on each edge with winc=1. At that edge:
    - If remain==0: go to IDLE.
    - Else: remain←remain−1, and cur_data←inv ? ~cur_data : cur_data.
    - If gap_ld==0 (and remain≠0): stay in ISSUE.
    - Else (remain≠0, gap_ld≠0): load gap_cnt←gap_ld and go to GAP.
  - wfull=1 in ISSUE: no write, state/data/remain hold (stall), indefinitely.
- GAP:
  - winc=0. gap_cnt decrements each edge.
  - The state returns to ISSUE on the edge where gap_cnt==1.
  - wfull is ignored while in GAP.
- cmd_abort=1 in ISSUE or GAP: winc forced 0 that cycle, and the next state is IDLE.
  - An abort in the same cycle as a would-be write suppresses that write.
  - cmd_abort in IDLE has no effect and does not block acceptance.
- busy = (state != IDLE).
- words_written increments by 1 on every edge with winc=1 and holds at 2^CNTW−1 (no wrap).
- Width rules:
  - remain is RW bits; gap_cnt is GW bits. Both are unsigned and never underflow, because of the transition rules above.
  - Inversion is full-width bitwise.

## Timing
- Reset (wrst=1, async): state=IDLE, winc=0, wdata=0, cmd_ready=0, busy=0, words_written=0; internal registers are cleared.
  - cmd_ready rises combinationally when wrst deasserts.
- Acceptance at edge E0: busy=1 and winc may be high in cycle E0–E1. The first write lands at E1 if wfull=0 (latency 1 cycle).
- With gap G and no stalls:
  - Writes land every G+1 cycles.
  - A command writes cmd_repeat+1 words in (cmd_repeat+1) + cmd_repeat·G cycles.
- The last write edge returns the state to IDLE. cmd_ready=1 in the following cycle.
  - A back-to-back command therefore has a 1-cycle bubble: its first write lands 2 edges after the previous last write.
- A wfull stall adds exactly one cycle per stalled cycle. The sequence, data order and count are unchanged.
- Reset mid-operation: the current command is discarded and no further winc pulses occur. No partial state survives.

## Test plan
- Reset: hold wrst=1 with cmd_valid=1 → winc=0, wdata=0x00, cmd_ready=0, words_written=0. Release → cmd_ready=1 immediately.
- Single write: cmd_data=0xA5, repeat=0, gap=0, wfull=0 → exactly one winc pulse with wdata=0xA5 one edge after acceptance; words_written=1; busy falls and cmd_ready returns next cycle.
- Pattern with gap: cmd_data=0x0F, repeat=3, gap=2, invert=1 → 4 writes 0x0F,0xF0,0x0F,0xF0 spaced exactly 3 cycles apart; words_written=4.
- Backpressure: repeat=15, gap=0, data=0x3C, invert=0; wfull=1 for 5 cycles after the 4th write → no winc while wfull=1; exactly 16 writes of 0x3C; the sequence takes 21 cycles.
- Abort: repeat=7, gap=0; assert cmd_abort in the cycle of the 3rd would-be write with wfull=0 → only 2 writes, no winc that cycle, IDLE and cmd_ready=1 next cycle.
- Reset mid-op: repeat=15, gap=1; pulse wrst asynchronously (mid-cycle) after 3 writes → winc drops immediately, words_written=0, no writes until a new command is accepted.
